// File: rtl/cnn_window_generator_pkg.sv
// Shared layer definitions for the CNN window generator and convolution processor:
// default geometry, sample width and window-generator FSM encodings.
package cnn_window_generator_pkg;

  localparam int unsigned CNN_CI     = 1;
  localparam int unsigned CNN_KX     = 3;
  localparam int unsigned CNN_KY     = 3;
  localparam int unsigned CNN_I_F_BW = 8;
  localparam int unsigned CNN_IW     = 28;
  localparam int unsigned CNN_IH     = 28;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } cnn_win_state_e;

endpackage

// File: rtl/cnn_line_buffer.sv
// One image-row delay line: DEPTH entries of W bits, advancing only when shift_en is high.
module cnn_line_buffer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] mem [DEPTH];

  // Contents need no reset: they are refilled before any window uses them.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/cnn_window_generator.sv
// Streaming KXxKY sliding-window generator (no padding) built on KY-1 chained line buffers.
// Define CNN_WIN_STRIDE2_EN to emit only windows on an even row/column stride-2 grid.
module cnn_window_generator
  import cnn_window_generator_pkg::*;
#(
  parameter int unsigned CI     = CNN_CI,
  parameter int unsigned KX     = CNN_KX,
  parameter int unsigned KY     = CNN_KY,
  parameter int unsigned I_F_BW = CNN_I_F_BW,
  parameter int unsigned IW     = CNN_IW,
  parameter int unsigned IH     = CNN_IH
) (
  input  logic                       clk,
  input  logic                       soft_rst,
  input  logic                       in_valid,
  input  logic [CI*I_F_BW-1:0]       in_pixel,
  output logic                       in_ready,
  output logic                       data_valid,
  output logic [CI*KX*KY*I_F_BW-1:0] feature_map,
  output logic                       frame_done
);

  localparam int unsigned PW    = CI * I_F_BW;
  localparam int unsigned FW    = CI * KX * KY * I_F_BW;
  localparam int unsigned COL_W = (IW > 1) ? $clog2(IW) : 1;
  localparam int unsigned ROW_W = (IH > 1) ? $clog2(IH) : 1;

  cnn_win_state_e state, state_nxt;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             hs;
  logic             col_last;
  logic             last_pix;
  logic             stride_ok;
  logic             emit;

  logic [PW-1:0] chain   [KY];
  logic [PW-1:0] win     [KY][KX];
  logic [PW-1:0] win_nxt [KY][KX];
  logic [FW-1:0] fm_nxt;

  assign hs       = in_valid && in_ready;
  assign col_last = (col == COL_W'(IW - 1));
  assign last_pix = col_last && (row == ROW_W'(IH - 1));

`ifdef CNN_WIN_STRIDE2_EN
  localparam logic ROW_PAR = 1'((KY - 1) % 2);
  localparam logic COL_PAR = 1'((KX - 1) % 2);
  assign stride_ok = (row[0] == ROW_PAR) && (col[0] == COL_PAR);
`else
  assign stride_ok = 1'b1;
`endif

  assign emit = hs && (row >= ROW_W'(KY - 1)) && (col >= COL_W'(KX - 1)) && stride_ok;

  // chain[d] carries the sample d rows above the incoming pixel, same column.
  assign chain[0] = in_pixel;

  for (genvar d = 0; d < int'(KY) - 1; d++) begin : g_lb
    cnn_line_buffer #(
      .DEPTH (IW),
      .W     (PW)
    ) u_lb (
      .clk      (clk),
      .shift_en (hs),
      .din      (chain[d]),
      .dout     (chain[d+1])
    );
  end

  // Next window: shift left one column, new right column from the line buffers.
  always_comb begin
    for (int ky = 0; ky < int'(KY); ky++) begin
      for (int kx = 0; kx < int'(KX) - 1; kx++) begin
        win_nxt[ky][kx] = win[ky][kx+1];
      end
      win_nxt[ky][KX-1] = chain[int'(KY) - 1 - ky];
    end
  end

  always_comb begin
    fm_nxt = '0;
    for (int ci = 0; ci < int'(CI); ci++) begin
      for (int ky = 0; ky < int'(KY); ky++) begin
        for (int kx = 0; kx < int'(KX); kx++) begin
          fm_nxt[((ci*int'(KY) + ky)*int'(KX) + kx)*int'(I_F_BW) +: I_F_BW] =
            win_nxt[ky][kx][ci*int'(I_F_BW) +: I_F_BW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      win <= win_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FILL:  if (hs && col_last && (row == ROW_W'(KY - 2))) state_nxt = S_RUN;
      S_RUN:   if (hs && last_pix) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  // Raster position of the next accepted pixel.
  always_ff @(posedge clk) begin
    if (soft_rst || (state == S_DONE)) begin
      col <= '0;
      row <= '0;
    end else if (hs) begin
      if (col_last) begin
        col <= '0;
        row <= (row == ROW_W'(IH - 1)) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
      feature_map <= '0;
      in_ready    <= 1'b1;
    end else begin
      data_valid <= emit;
      frame_done <= hs && last_pix;
      in_ready   <= (state_nxt != S_DONE);
      if (emit) begin
        feature_map <= fm_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cnn_window_generator.sv
// Directed bench for cnn_window_generator on a 5x5 image with a 3x3 window (CI=1 and CI=2).
module tb_cnn_window_generator;

  localparam int unsigned IW  = 5;
  localparam int unsigned IH  = 5;
  localparam int unsigned KX  = 3;
  localparam int unsigned KY  = 3;
  localparam int unsigned BW  = 8;
  localparam int unsigned FW1 = KX * KY * BW;
  localparam int unsigned FW2 = 2 * FW1;
`ifdef CNN_WIN_STRIDE2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int NWIN = ((int'(IH) - int'(KY)) / STEP + 1) * ((int'(IW) - int'(KX)) / STEP + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           soft_rst;
  logic           in_valid;
  logic [BW-1:0]  in_pixel;
  logic           in_ready;
  logic           data_valid;
  logic [FW1-1:0] feature_map;
  logic           frame_done;

  logic           in_valid2;
  logic [2*BW-1:0] in_pixel2;
  logic           in_ready2;
  logic           data_valid2;
  logic [FW2-1:0] feature_map2;
  logic           frame_done2;

  cnn_window_generator #(.CI(1), .KX(KX), .KY(KY), .I_F_BW(BW), .IW(IW), .IH(IH)) dut (
    .clk         (clk),
    .soft_rst    (soft_rst),
    .in_valid    (in_valid),
    .in_pixel    (in_pixel),
    .in_ready    (in_ready),
    .data_valid  (data_valid),
    .feature_map (feature_map),
    .frame_done  (frame_done)
  );

  cnn_window_generator #(.CI(2), .KX(KX), .KY(KY), .I_F_BW(BW), .IW(IW), .IH(IH)) dut2 (
    .clk         (clk),
    .soft_rst    (soft_rst),
    .in_valid    (in_valid2),
    .in_pixel    (in_pixel2),
    .in_ready    (in_ready2),
    .data_valid  (data_valid2),
    .feature_map (feature_map2),
    .frame_done  (frame_done2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [FW1-1:0] win_q [$];
  bit             fd_q  [$];
  bit             rdy_q [$];
  int             hsi_q [$];
  int hs_cnt, idle_dv, stalls, timeouts, cycles, fd_alone;

  // Window with top-left pixel (r0,c0) when pixel value = row*IW+col.
  function automatic logic [FW1-1:0] exp_win(input int r0, input int c0);
    logic [FW1-1:0] w;
    w = '0;
    for (int ky = 0; ky < int'(KY); ky++)
      for (int kx = 0; kx < int'(KX); kx++)
        w[(ky*int'(KX) + kx)*int'(BW) +: BW] = 8'((r0 + ky)*int'(IW) + c0 + kx);
    return w;
  endfunction

  task automatic clear_log();
    win_q.delete(); fd_q.delete(); rdy_q.delete(); hsi_q.delete();
    hs_cnt = 0; idle_dv = 0; stalls = 0; timeouts = 0; cycles = 0; fd_alone = 0;
  endtask

  task automatic record(input bit was_hs);
    cycles++;
    if (data_valid === 1'b1) begin
      win_q.push_back(feature_map);
      fd_q.push_back(frame_done);
      rdy_q.push_back(in_ready);
      hsi_q.push_back(hs_cnt);
      if (!was_hs) idle_dv++;
    end else if (frame_done === 1'b1) begin
      fd_alone++;
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
    record(1'b0);
  endtask

  // Send npix raster pixels (value = index mod frame size), optionally with random idle gaps.
  task automatic drive(input int npix, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      int g;
      int guard;
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      repeat (g) idle_cycle();
      guard = 0;
      while (in_ready !== 1'b1 && guard < 20) begin
        idle_cycle();
        stalls++;
        guard++;
      end
      if (in_ready !== 1'b1) timeouts++;
      in_valid = 1'b1;
      in_pixel = 8'(i % int'(IW*IH));
      hs_cnt++;
      @(posedge clk); #1;
      record(1'b1);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    soft_rst = 1'b1; in_valid = 1'b0; in_pixel = '0; in_valid2 = 1'b0; in_pixel2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (feature_map !== '0) begin n_fail++; $display("FAIL reset_feature_map: got %h expected 0", feature_map); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    soft_rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_data_valid: got %b expected 0", data_valid); end
  endtask

  task automatic test_continuous();
    int k;
    clear_log();
    drive(25, 1'b0);
    n_checks++; if (win_q.size() != NWIN) begin n_fail++; $display("FAIL cont_count: got %0d expected %0d", win_q.size(), NWIN); end
    k = 0;
    for (int r0 = 0; r0 <= int'(IH - KY); r0 += STEP) begin
      for (int c0 = 0; c0 <= int'(IW - KX); c0 += STEP) begin
        if (k < win_q.size()) begin
          n_checks++; if (win_q[k] !== exp_win(r0, c0)) begin n_fail++; $display("FAIL cont_window[%0d]: got %h expected %h", k, win_q[k], exp_win(r0, c0)); end
          n_checks++; if (hsi_q[k] != (r0 + 2)*int'(IW) + c0 + 2 + 1) begin n_fail++; $display("FAIL cont_latency[%0d]: got handshake %0d expected %0d", k, hsi_q[k], (r0 + 2)*int'(IW) + c0 + 3); end
          n_checks++; if (fd_q[k] != (k == NWIN - 1)) begin n_fail++; $display("FAIL cont_frame_done[%0d]: got %b expected %b", k, fd_q[k], (k == NWIN - 1)); end
        end
        k++;
      end
    end
    if (rdy_q.size() > 0) begin
      n_checks++; if (rdy_q[rdy_q.size()-1] !== 1'b0) begin n_fail++; $display("FAIL cont_last_in_ready: got %b expected 0", rdy_q[rdy_q.size()-1]); end
    end
    n_checks++; if (fd_alone != 0) begin n_fail++; $display("FAIL cont_lone_frame_done: got %0d expected 0", fd_alone); end
    n_checks++; if (timeouts != 0) begin n_fail++; $display("FAIL cont_ready_timeout: got %0d expected 0", timeouts); end
    idle_cycle();
  endtask

  task automatic test_gaps();
    int k;
    clear_log();
    drive(25, 1'b1);
    n_checks++; if (win_q.size() != NWIN) begin n_fail++; $display("FAIL gaps_count: got %0d expected %0d", win_q.size(), NWIN); end
    n_checks++; if (idle_dv != 0) begin n_fail++; $display("FAIL gaps_idle_valid: got %0d expected 0", idle_dv); end
    k = 0;
    for (int r0 = 0; r0 <= int'(IH - KY); r0 += STEP) begin
      for (int c0 = 0; c0 <= int'(IW - KX); c0 += STEP) begin
        if (k < win_q.size()) begin
          n_checks++; if (win_q[k] !== exp_win(r0, c0)) begin n_fail++; $display("FAIL gaps_window[%0d]: got %h expected %h", k, win_q[k], exp_win(r0, c0)); end
          n_checks++; if (fd_q[k] != (k == NWIN - 1)) begin n_fail++; $display("FAIL gaps_frame_done[%0d]: got %b expected %b", k, fd_q[k], (k == NWIN - 1)); end
        end
        k++;
      end
    end
    n_checks++; if (timeouts != 0) begin n_fail++; $display("FAIL gaps_ready_timeout: got %0d expected 0", timeouts); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    clear_log();
    drive(50, 1'b0);
    n_checks++; if (win_q.size() != 2*NWIN) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", win_q.size(), 2*NWIN); end
    n_checks++; if (stalls != 1) begin n_fail++; $display("FAIL b2b_bubbles: got %0d expected 1", stalls); end
    n_checks++; if (cycles != 51) begin n_fail++; $display("FAIL b2b_cycles: got %0d expected 51", cycles); end
    if (win_q.size() == 2*NWIN) begin
      n_checks++; if (win_q[NWIN] !== exp_win(0, 0)) begin n_fail++; $display("FAIL b2b_second_first_window: got %h expected %h", win_q[NWIN], exp_win(0, 0)); end
      n_checks++; if (hsi_q[NWIN] != 38) begin n_fail++; $display("FAIL b2b_second_latency: got handshake %0d expected 38", hsi_q[NWIN]); end
      n_checks++; if (fd_q[NWIN-1] !== 1'b1 || fd_q[2*NWIN-1] !== 1'b1) begin n_fail++; $display("FAIL b2b_frame_done: got %b%b expected 11", fd_q[NWIN-1], fd_q[2*NWIN-1]); end
      n_checks++; if (win_q[2*NWIN-1] !== exp_win(int'(IH - KY), int'(IW - KX))) begin n_fail++; $display("FAIL b2b_last_window: got %h expected %h", win_q[2*NWIN-1], exp_win(int'(IH - KY), int'(IW - KX))); end
    end
    idle_cycle();
  endtask

  task automatic test_soft_rst();
    clear_log();
    drive(17, 1'b0);
    soft_rst = 1'b1;
    in_valid = 1'b1;
    in_pixel = 8'hAA;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL srst_data_valid[%0d]: got %b expected 0", c, data_valid); end
    end
    soft_rst = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL srst_in_ready: got %b expected 1", in_ready); end
    clear_log();
    drive(25, 1'b0);
    n_checks++; if (win_q.size() != NWIN) begin n_fail++; $display("FAIL srst_count: got %0d expected %0d", win_q.size(), NWIN); end
    if (win_q.size() == NWIN) begin
      n_checks++; if (hsi_q[0] != 13) begin n_fail++; $display("FAIL srst_first_latency: got handshake %0d expected 13", hsi_q[0]); end
      n_checks++; if (win_q[0] !== exp_win(0, 0)) begin n_fail++; $display("FAIL srst_first_window: got %h expected %h", win_q[0], exp_win(0, 0)); end
      n_checks++; if (win_q[NWIN-1] !== exp_win(int'(IH - KY), int'(IW - KX)) || fd_q[NWIN-1] !== 1'b1) begin n_fail++; $display("FAIL srst_last_window: got %h fd=%b expected %h fd=1", win_q[NWIN-1], fd_q[NWIN-1], exp_win(int'(IH - KY), int'(IW - KX))); end
    end
    idle_cycle();
  endtask

  task automatic test_multichannel();
    logic [FW2-1:0] exp;
    int early;
    exp = '0;
    for (int ky = 0; ky < int'(KY); ky++)
      for (int kx = 0; kx < int'(KX); kx++) begin
        exp[(ky*int'(KX) + kx)*int'(BW) +: BW]                 = 8'(ky*int'(IW) + kx);
        exp[((int'(KY) + ky)*int'(KX) + kx)*int'(BW) +: BW]    = 8'(100 + ky*int'(IW) + kx);
      end
    early = 0;
    for (int i = 0; i < 13; i++) begin
      in_valid2 = 1'b1;
      in_pixel2 = {8'(i + 100), 8'(i)};
      @(posedge clk); #1;
      if (i < 12 && data_valid2 !== 1'b0) early++;
    end
    in_valid2 = 1'b0;
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL ci2_early_valid: got %0d expected 0", early); end
    n_checks++; if (data_valid2 !== 1'b1) begin n_fail++; $display("FAIL ci2_data_valid: got %b expected 1", data_valid2); end
    n_checks++; if (feature_map2 !== exp) begin n_fail++; $display("FAIL ci2_window: got %h expected %h", feature_map2, exp); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_soft_rst();
    test_multichannel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
